// File: rtl/spi_ram_pkg.sv
// Shared encodings for the SPI RAM command decoder: opcodes carried in din[9:8]
// and the controller FSM states.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WADDR = 2'b00,
        OP_WDATA = 2'b01,
        OP_RADDR = 2'b10,
        OP_RDATA = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WADDR = 2'b01,
        ST_RADDR = 2'b10,
        ST_RDATA = 2'b11
    } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte RAM: synchronous write and registered read on one address.
// Contents are never reset.
module spi_ram_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between an SPI slave and a byte RAM: one command per rising
// edge of rx_valid, write/read address pointers, held read data and error pulse.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       seq_err
);

    state_t                 state_q, state_d;
    opcode_t                op;
    logic                   rx_valid_q;
    logic                   rx_armed;
    logic                   accept;
    logic                   mem_we;
    logic                   rd_start;
    logic                   rd_pend;
    logic                   illegal;
    logic [ADDR_SIZE-1:0]   wr_addr;
    logic [ADDR_SIZE-1:0]   rd_addr;
    logic [ADDR_SIZE-1:0]   mem_addr;
    logic [7:0]             mem_rdata;

    // rx_armed blocks a level that was already high when reset released.
    assign accept   = rx_valid & ~rx_valid_q & rx_armed;
    assign op       = opcode_t'(din[9:8]);
    assign mem_addr = mem_we ? wr_addr : rd_addr;

    spi_ram_mem #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(din[7:0]),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_we   = 1'b0;
        rd_start = 1'b0;
        illegal  = 1'b0;
        if (accept) begin
            case (op)
                OP_WADDR: state_d = ST_WADDR;
                OP_RADDR: state_d = ST_RADDR;
                OP_WDATA: begin
                    if (state_q == ST_WADDR) begin
                        mem_we = 1'b1;
                    end else begin
                        illegal = 1'b1;
                        if (state_q == ST_RDATA) state_d = ST_IDLE;
                    end
                end
                OP_RDATA: begin
                    if (state_q == ST_RADDR) begin
                        rd_start = 1'b1;
                        state_d  = ST_RDATA;
                    end else begin
                        illegal = 1'b1;
                        if (state_q == ST_RDATA) state_d = ST_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // RAM read data lands the cycle after the accept; it is latched into dout
    // so later writes to the same location cannot disturb the held value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_armed   <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_pend    <= 1'b0;
            dout       <= 8'h00;
            tx_valid   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            rx_armed   <= rx_armed | ~rx_valid;
            seq_err    <= illegal;
            rd_pend    <= rd_start;
            if (accept && op == OP_WADDR) wr_addr <= din[ADDR_SIZE-1:0];
            if (mem_we) wr_addr <= wr_addr + 1'b1;
            if (accept && op == OP_RADDR) rd_addr <= din[ADDR_SIZE-1:0];
            if (accept) tx_valid <= 1'b0;
            if (rd_pend) begin
                dout     <= mem_rdata;
                tx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width; legal range 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din  input  10  command word from SPI slave rx_data; [9:8] opcode, [7:0] payload.
REQ-006 SHALL have port rx_valid  input  1  din valid; may stay high many cycles per word.
REQ-007 SHALL have port dout  output  8  read data to SPI slave tx_data.
REQ-008 SHALL have port tx_valid  output  1  dout valid, level, to SPI slave.
REQ-009 SHALL have port seq_err  output  1  one-cycle pulse on an illegal command sequence.

Function
REQ-010 SHALL accept one command per rising edge of rx_valid (rx_valid high, registered rx_valid_q low); rx_valid held high SHALL NOT re-trigger.
REQ-011 SHALL decode opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-012 SHALL implement FSM states IDLE, WADDR, RADDR, RDATA; state changes only on an accepted command.
REQ-013 Opcode 00 in any state SHALL load wr_addr <= din[ADDR_SIZE-1:0] and go to WADDR.
REQ-014 Opcode 10 in any state SHALL load rd_addr <= din[ADDR_SIZE-1:0] and go to RADDR.
REQ-015 Opcode 01 in WADDR SHALL write din[7:0] to mem[wr_addr] at the accepting edge, then increment wr_addr; FSM stays in WADDR.
REQ-016 wr_addr increment SHALL wrap MEM_DEPTH-1 -> 0.
REQ-017 Opcode 11 in RADDR SHALL drive dout = mem[rd_addr] and tx_valid = 1 exactly one cycle after the accepting edge, then go to RDATA.
REQ-018 In RDATA, dout and tx_valid SHALL hold stable until the next accepted command; tx_valid clears on that command's accepting edge.
REQ-019 Opcode 01 outside WADDR, or opcode 11 outside RADDR (including 11 in RDATA), SHALL pulse seq_err for one cycle with no memory or address change; state stays unchanged, except RDATA, which goes to IDLE.
REQ-020 A write to mem[rd_addr] while in RDATA SHALL NOT change the held dout.
REQ-021 Payload bits above ADDR_SIZE in address commands SHALL be ignored.
REQ-022 rx_valid rising in the same cycle as a tx_valid clear SHALL be handled as a normal accepted command.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, dout 8'h00, tx_valid 0, seq_err 0, wr_addr 0, rd_addr 0, rx_valid_q 0.
REQ-024 Memory contents SHALL NOT be reset and SHALL retain values across reset.
REQ-025 Reset asserted mid-read SHALL drop tx_valid immediately; after release, opcode 11 SHALL raise seq_err until a new opcode 10.
REQ-026 rx_valid already high at reset release SHALL NOT count as a rising edge until it returns low.

Structure
REQ-027 Opcode encodings and FSM state encodings SHALL live in shared package spi_ram_pkg, also used by the SPI slave bench.
REQ-028 Storage SHALL be a sub-module spi_ram_mem (MEM_DEPTH x 8, synchronous write, synchronous read, one port); decode, FSM and address registers stay in spi_ram_ctrl.

Verification
REQ-029 Write then read: 10'h0_12 (write addr 0x12), 10'h1_A5, 10'h2_12, 10'h3_00 -> one cycle after the last accept, dout=8'hA5 and tx_valid=1; both held until the next command.
REQ-030 Burst and wrap: 10'h0_FF, then 10'h1_11, 10'h1_22 -> mem[0xFF]=0x11 and mem[0x00]=0x22; reading 0x00 returns 8'h22.
REQ-031 Held rx_valid: 10'h1_33 after 10'h0_40, with rx_valid high for 10 cycles -> only mem[0x40] is written; mem[0x41] is unchanged.
REQ-032 Sequence errors: opcode 11 from IDLE -> one-cycle seq_err, tx_valid stays 0. Opcode 01 right after 10'h2_05 -> seq_err, no write occurs.
REQ-033 Reset mid-read: rst_n low while tx_valid=1 -> tx_valid=0 in the same cycle. After release, 10'h3_00 -> seq_err; memory value at the previous address is intact on re-read.
